// File: rtl/tensor_burst_controller.sv
// Burst sequencer moving one or all matrices between the CPU stream and the tensor register file.
// Write: 1-cycle accept-to-strobe. Read: registered beat, held under read_ready_in backpressure.
module tensor_burst_controller #(
  parameter int DATA_WIDTH   = 8,
  parameter int MATRIX_DIM   = 3,
  parameter int NUM_MATRICES = 2,
  parameter int LANES        = 2,
  localparam int ELEMS       = MATRIX_DIM * MATRIX_DIM,
  localparam int TOTAL_ALL   = NUM_MATRICES * ELEMS,
  localparam int AW          = $clog2(TOTAL_ALL),
  localparam int SW          = $clog2(NUM_MATRICES + 1),
  localparam int PW          = LANES * DATA_WIDTH
) (
  input  logic          clock_in,
  input  logic          reset_in,
  input  logic          start_in,
  input  logic          direction_in,
  input  logic [SW-1:0] matrix_select_in,
  input  logic          abort_in,
  input  logic [PW-1:0] write_data_in,
  input  logic          write_valid_in,
  output logic          write_ready_out,
  output logic          rf_write_enable_out,
  output logic [AW-1:0] rf_write_address_out,
  output logic [PW-1:0] rf_write_data_out,
  output logic [LANES-1:0] rf_lane_mask_out,
  output logic [AW-1:0] rf_read_address_out,
  input  logic [PW-1:0] rf_read_data_in,
  output logic [PW-1:0] read_data_out,
  output logic          read_valid_out,
  input  logic          read_ready_in,
  output logic          busy_out,
  output logic          done_out,
  output logic          error_out
);

  localparam int CW        = $clog2(TOTAL_ALL + 1);
  localparam int BEATS_ONE = (ELEMS + LANES - 1) / LANES;
  localparam int BEATS_ALL = (TOTAL_ALL + LANES - 1) / LANES;
  localparam int BW        = $clog2(BEATS_ALL + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t           r_state;
  logic [AW-1:0]    r_addr;
  logic [CW-1:0]    r_total;
  logic [BW-1:0]    r_beat;
  logic [BW-1:0]    r_last_beat;
  logic             r_wr_rdy;
  logic             r_rf_we;
  logic [AW-1:0]    r_rf_waddr;
  logic [PW-1:0]    r_rf_wdata;
  logic [LANES-1:0] r_mask;
  logic [PW-1:0]    r_rd_dat;
  logic             r_rd_vld;
  logic             r_done;
  logic             r_error;

  logic [LANES-1:0] w_mask;
  logic [PW-1:0]    w_rd_masked;
  logic             w_last;

  // Lane l of the current beat is live while beat*LANES+l stays inside the burst.
  always_comb begin
    w_mask = '0;
    for (int l = 0; l < LANES; l++) begin
      w_mask[LANES-1-l] = (int'(r_beat) * LANES + l) < int'(r_total);
    end
  end

  always_comb begin
    w_rd_masked = '0;
    for (int l = 0; l < LANES; l++) begin
      if (w_mask[LANES-1-l]) begin
        w_rd_masked[(LANES-l)*DATA_WIDTH-1 -: DATA_WIDTH] =
          rf_read_data_in[(LANES-l)*DATA_WIDTH-1 -: DATA_WIDTH];
      end
    end
  end

  assign w_last = (r_beat == r_last_beat);

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_total     <= '0;
      r_beat      <= '0;
      r_last_beat <= '0;
      r_wr_rdy    <= 1'b0;
      r_rf_we     <= 1'b0;
      r_rf_waddr  <= '0;
      r_rf_wdata  <= '0;
      r_mask      <= '0;
      r_rd_dat    <= '0;
      r_rd_vld    <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_rf_we <= 1'b0;
      if (abort_in && r_state != IDLE) begin
        // Any beat presented alongside the abort is dropped on purpose.
        r_state  <= IDLE;
        r_rd_vld <= 1'b0;
        r_wr_rdy <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start_in) begin
              if (matrix_select_in > SW'(NUM_MATRICES)) begin
                r_error <= 1'b1;
              end else begin
                r_beat <= '0;
                if (matrix_select_in == SW'(NUM_MATRICES)) begin
                  r_addr      <= '0;
                  r_total     <= CW'(TOTAL_ALL);
                  r_last_beat <= BW'(BEATS_ALL - 1);
                end else begin
                  r_addr      <= AW'(int'(matrix_select_in) * ELEMS);
                  r_total     <= CW'(ELEMS);
                  r_last_beat <= BW'(BEATS_ONE - 1);
                end
                if (direction_in) begin
                  r_state  <= WRITE;
                  r_wr_rdy <= 1'b1;
                end else begin
                  r_state  <= READ;
                end
              end
            end
          end
          WRITE: begin
            if (write_valid_in && r_wr_rdy) begin
              r_rf_we    <= 1'b1;
              r_rf_waddr <= r_addr;
              r_rf_wdata <= write_data_in;
              r_mask     <= w_mask;
              r_addr     <= r_addr + AW'(LANES);
              r_beat     <= r_beat + 1'b1;
              if (w_last) begin
                r_state  <= IDLE;
                r_wr_rdy <= 1'b0;
                r_done   <= 1'b1;
              end
            end
          end
          READ: begin
            if (!r_rd_vld || read_ready_in) begin
              r_rd_dat <= w_rd_masked;
              r_rd_vld <= 1'b1;
              r_mask   <= w_mask;
              r_addr   <= r_addr + AW'(LANES);
              r_beat   <= r_beat + 1'b1;
              if (w_last) begin
                r_state <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (r_rd_vld && read_ready_in) begin
              r_rd_vld <= 1'b0;
              r_state  <= IDLE;
              r_done   <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign write_ready_out      = r_wr_rdy;
  assign rf_write_enable_out  = r_rf_we;
  assign rf_write_address_out = r_rf_waddr;
  assign rf_write_data_out    = r_rf_wdata;
  assign rf_lane_mask_out     = r_mask;
  assign rf_read_address_out  = (r_state == READ) ? r_addr : '0;
  assign read_data_out        = r_rd_dat;
  assign read_valid_out       = r_rd_vld;
  assign busy_out             = (r_state != IDLE);
  assign done_out             = r_done;
  assign error_out            = r_error;

endmodule

// File: tb/tb_tensor_burst_controller.sv
// Directed bench for tensor_burst_controller: default instance plus a DIM=4/LANES=4/3-matrix instance.
module tb_tensor_burst_controller;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Default instance (DW=8, DIM=3, NM=2, LANES=2): AW=5, SW=2, PW=16
  logic        d_start, d_dir, d_abort, d_wvld, d_wrdy, d_rf_we, d_rd_vld, d_rd_rdy;
  logic        d_busy, d_done, d_err;
  logic [1:0]  d_sel, d_mask;
  logic [15:0] d_wdata, d_rf_wdata, d_rf_rdata, d_rd_data;
  logic [4:0]  d_rf_waddr, d_rf_raddr;

  // Sweep instance (DW=8, DIM=4, NM=3, LANES=4): AW=6, SW=2, PW=32
  logic        s_start, s_dir, s_abort, s_wvld, s_wrdy, s_rf_we, s_rd_vld, s_rd_rdy;
  logic        s_busy, s_done, s_err;
  logic [1:0]  s_sel;
  logic [3:0]  s_mask;
  logic [31:0] s_wdata, s_rf_wdata, s_rf_rdata, s_rd_data;
  logic [5:0]  s_rf_waddr, s_rf_raddr;

  // Register-file read model: lane0 = addr+0x10, lane1 = addr+0x11
  assign d_rf_rdata = {8'(d_rf_raddr) + 8'h10, 8'(d_rf_raddr) + 8'h11};
  assign s_rf_rdata = '0;

  tensor_burst_controller dut (
    .clock_in(clk), .reset_in(rst), .start_in(d_start), .direction_in(d_dir),
    .matrix_select_in(d_sel), .abort_in(d_abort), .write_data_in(d_wdata),
    .write_valid_in(d_wvld), .write_ready_out(d_wrdy), .rf_write_enable_out(d_rf_we),
    .rf_write_address_out(d_rf_waddr), .rf_write_data_out(d_rf_wdata),
    .rf_lane_mask_out(d_mask), .rf_read_address_out(d_rf_raddr),
    .rf_read_data_in(d_rf_rdata), .read_data_out(d_rd_data), .read_valid_out(d_rd_vld),
    .read_ready_in(d_rd_rdy), .busy_out(d_busy), .done_out(d_done), .error_out(d_err)
  );

  tensor_burst_controller #(.DATA_WIDTH(8), .MATRIX_DIM(4), .NUM_MATRICES(3), .LANES(4)) dut_s (
    .clock_in(clk), .reset_in(rst), .start_in(s_start), .direction_in(s_dir),
    .matrix_select_in(s_sel), .abort_in(s_abort), .write_data_in(s_wdata),
    .write_valid_in(s_wvld), .write_ready_out(s_wrdy), .rf_write_enable_out(s_rf_we),
    .rf_write_address_out(s_rf_waddr), .rf_write_data_out(s_rf_wdata),
    .rf_lane_mask_out(s_mask), .rf_read_address_out(s_rf_raddr),
    .rf_read_data_in(s_rf_rdata), .read_data_out(s_rd_data), .read_valid_out(s_rd_vld),
    .read_ready_in(s_rd_rdy), .busy_out(s_busy), .done_out(s_done), .error_out(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wrdy"},   64'(d_wrdy),     64'd0);
    check({tag, "_rf_we"},  64'(d_rf_we),    64'd0);
    check({tag, "_waddr"},  64'(d_rf_waddr), 64'd0);
    check({tag, "_wdata"},  64'(d_rf_wdata), 64'd0);
    check({tag, "_mask"},   64'(d_mask),     64'd0);
    check({tag, "_raddr"},  64'(d_rf_raddr), 64'd0);
    check({tag, "_rdata"},  64'(d_rd_data),  64'd0);
    check({tag, "_rvld"},   64'(d_rd_vld),   64'd0);
    check({tag, "_busy"},   64'(d_busy),     64'd0);
    check({tag, "_done"},   64'(d_done),     64'd0);
    check({tag, "_err"},    64'(d_err),      64'd0);
  endtask

  function automatic logic [15:0] rexp(input int a, input logic [1:0] m);
    logic [7:0] hi, lo;
    hi = m[1] ? 8'(a + 16) : 8'h00;
    lo = m[0] ? 8'(a + 17) : 8'h00;
    return {hi, lo};
  endfunction

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    d_start = 0; d_dir = 0; d_sel = 0; d_abort = 0; d_wdata = '0; d_wvld = 0; d_rd_rdy = 0;
    s_start = 0; s_dir = 0; s_sel = 0; s_abort = 0; s_wdata = '0; s_wvld = 0; s_rd_rdy = 0;
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single-matrix write, sel=1: addresses 9..17, last mask 2'b10
    d_start = 1; d_dir = 1; d_sel = 2'd1;
    tick();
    d_start = 0;
    check("wr1_busy", 64'(d_busy), 64'd1);
    check("wr1_wrdy", 64'(d_wrdy), 64'd1);
    check("wr1_we0",  64'(d_rf_we), 64'd0);
    for (int k = 0; k < 5; k++) begin
      d_wdata = 16'hA000 + 16'(k);
      d_wvld  = 1;
      tick();
      check("wr1_we",    64'(d_rf_we),    64'd1);
      check("wr1_addr",  64'(d_rf_waddr), 64'(9 + 2 * k));
      check("wr1_data",  64'(d_rf_wdata), 64'(16'hA000 + 16'(k)));
      check("wr1_mask",  64'(d_mask),     (k < 4) ? 64'd3 : 64'd2);
      check("wr1_done",  64'(d_done),     (k == 4) ? 64'd1 : 64'd0);
      check("wr1_busyk", 64'(d_busy),     (k == 4) ? 64'd0 : 64'd1);
    end
    d_wvld = 0;
    tick();
    check("wr1_post_we",   64'(d_rf_we), 64'd0);
    check("wr1_post_done", 64'(d_done),  64'd0);

    // Full read, sel=2, ready held high: 9 beats at 0,2,..,16
    d_start = 1; d_dir = 0; d_sel = 2'd2; d_rd_rdy = 1;
    tick();
    d_start = 0;
    check("rdall_raddr0", 64'(d_rf_raddr), 64'd0);
    check("rdall_vld0",   64'(d_rd_vld),   64'd0);
    for (int k = 0; k < 9; k++) begin
      tick();
      check("rdall_vld",  64'(d_rd_vld),  64'd1);
      check("rdall_data", 64'(d_rd_data), 64'(rexp(2 * k, 2'b11)));
      check("rdall_mask", 64'(d_mask),    64'd3);
      check("rdall_done", 64'(d_done),    64'd0);
      check("rdall_busy", 64'(d_busy),    64'd1);
      if (k < 8) check("rdall_raddr", 64'(d_rf_raddr), 64'(2 * (k + 1)));
    end
    tick();
    check("rdall_end_vld",  64'(d_rd_vld), 64'd0);
    check("rdall_end_done", 64'(d_done),   64'd1);
    check("rdall_end_busy", 64'(d_busy),   64'd0);
    tick();
    check("rdall_done_once", 64'(d_done), 64'd0);

    // Read backpressure, sel=1: stall 3 cycles holding beat 1
    d_start = 1; d_dir = 0; d_sel = 2'd1; d_rd_rdy = 1;
    tick();
    d_start = 0;
    check("rbp_raddr0", 64'(d_rf_raddr), 64'd9);
    tick();
    check("rbp_b0", 64'(d_rd_data), 64'(rexp(9, 2'b11)));
    tick();
    check("rbp_b1", 64'(d_rd_data), 64'(rexp(11, 2'b11)));
    d_rd_rdy = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rbp_hold_data",  64'(d_rd_data),  64'(rexp(11, 2'b11)));
      check("rbp_hold_raddr", 64'(d_rf_raddr), 64'd13);
      check("rbp_hold_vld",   64'(d_rd_vld),   64'd1);
    end
    d_rd_rdy = 1;
    tick();
    check("rbp_b2", 64'(d_rd_data), 64'(rexp(13, 2'b11)));
    tick();
    check("rbp_b3", 64'(d_rd_data), 64'(rexp(15, 2'b11)));
    tick();
    check("rbp_b4",      64'(d_rd_data), 64'(rexp(17, 2'b10)));
    check("rbp_b4_mask", 64'(d_mask),    64'd2);
    check("rbp_b4_done", 64'(d_done),    64'd0);
    tick();
    check("rbp_done", 64'(d_done), 64'd1);
    check("rbp_vld",  64'(d_rd_vld), 64'd0);
    tick();

    // Write stall then abort, sel=0
    d_start = 1; d_dir = 1; d_sel = 2'd0;
    tick();
    d_start = 0;
    d_wvld = 1; d_wdata = 16'h1111;
    tick();
    check("ab_we0",   64'(d_rf_we),    64'd1);
    check("ab_addr0", 64'(d_rf_waddr), 64'd0);
    d_wdata = 16'h2222;
    tick();
    check("ab_addr1", 64'(d_rf_waddr), 64'd2);
    d_wvld = 0;
    tick();
    check("ab_gap_we1", 64'(d_rf_we), 64'd0);
    check("ab_gap_bsy", 64'(d_busy),  64'd1);
    tick();
    check("ab_gap_we2", 64'(d_rf_we), 64'd0);
    d_wvld = 1; d_wdata = 16'h3333;
    tick();
    check("ab_we2",   64'(d_rf_we),    64'd1);
    check("ab_addr2", 64'(d_rf_waddr), 64'd4);
    d_abort = 1; d_wdata = 16'h4444;
    tick();
    d_abort = 0; d_wvld = 0;
    check("ab_we_after",   64'(d_rf_we), 64'd0);
    check("ab_busy_after", 64'(d_busy),  64'd0);
    check("ab_done_after", 64'(d_done),  64'd0);
    check("ab_wrdy_after", 64'(d_wrdy),  64'd0);
    tick();
    check("ab_we_later",   64'(d_rf_we), 64'd0);
    check("ab_done_later", 64'(d_done),  64'd0);

    // Reset in the middle of a read
    d_start = 1; d_dir = 0; d_sel = 2'd2; d_rd_rdy = 1;
    tick();
    d_start = 0;
    tick(); tick();
    check("mrst_vld_before", 64'(d_rd_vld), 64'd1);
    rst = 1;
    tick();
    check_reset_outputs("mrst");
    rst = 0;
    tick();
    check("mrst_no_done", 64'(d_done), 64'd0);

    // Illegal select
    d_start = 1; d_dir = 1; d_sel = 2'd3;
    tick();
    d_start = 0;
    check("ill_err",  64'(d_err),  64'd1);
    check("ill_busy", 64'(d_busy), 64'd0);
    tick();
    check("ill_err_pulse", 64'(d_err),  64'd0);
    check("ill_busy2",     64'(d_busy), 64'd0);

    // Start while busy is ignored: write sel=0 continues as a write
    d_start = 1; d_dir = 1; d_sel = 2'd0;
    tick();
    d_dir = 0; d_sel = 2'd1;
    for (int k = 0; k < 5; k++) begin
      d_wvld = 1; d_wdata = 16'h5000 + 16'(k);
      tick();
      d_start = 0;
      check("ign_we",   64'(d_rf_we),    64'd1);
      check("ign_addr", 64'(d_rf_waddr), 64'(2 * k));
      check("ign_mask", 64'(d_mask),     (k < 4) ? 64'd3 : 64'd2);
      check("ign_done", 64'(d_done),     (k == 4) ? 64'd1 : 64'd0);
      check("ign_rvld", 64'(d_rd_vld),   64'd0);
    end
    d_wvld = 0;
    tick();
    check("ign_idle", 64'(d_busy), 64'd0);

    // Sweep instance: full write of 3 4x4 matrices in 12 four-lane beats
    s_start = 1; s_dir = 1; s_sel = 2'd3;
    tick();
    s_start = 0;
    check("sw_busy", 64'(s_busy), 64'd1);
    for (int k = 0; k < 12; k++) begin
      s_wvld = 1; s_wdata = 32'hC0DE0000 + 32'(k);
      tick();
      check("sw_we",   64'(s_rf_we),    64'd1);
      check("sw_addr", 64'(s_rf_waddr), 64'(4 * k));
      check("sw_data", 64'(s_rf_wdata), 64'(32'hC0DE0000 + 32'(k)));
      check("sw_mask", 64'(s_mask),     64'hF);
      check("sw_done", 64'(s_done),     (k == 11) ? 64'd1 : 64'd0);
    end
    s_wvld = 0;
    check("sw_last_addr", 64'(s_rf_waddr), 64'd44);
    tick();
    check("sw_idle", 64'(s_busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
